// File: rtl/imem_boot_if.sv
// Loader handshake, fetch path and instruction-memory port of the boot controller.
// The controller takes the master modport; the loader/core/memory side takes slave.
interface imem_boot_if #(
  parameter int ADDR_W = 5
);
  logic              load_valid;
  logic              load_ready;
  logic [31:0]       load_data;
  logic              load_last;
  logic              reload_req;
  logic [31:0]       PCF;
  logic [31:0]       instruction;
  logic              core_stall;
  logic              fetch_fault;
  logic              load_err;
  logic [ADDR_W:0]   word_count;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [31:0]       mem_wdata;
  logic [ADDR_W-1:0] mem_raddr;
  logic [31:0]       mem_rdata;

  modport master (
    input  load_valid, load_data, load_last, reload_req, PCF, mem_rdata,
    output load_ready, instruction, core_stall, fetch_fault, load_err,
           word_count, mem_we, mem_waddr, mem_wdata, mem_raddr
  );

  modport slave (
    output load_valid, load_data, load_last, reload_req, PCF, mem_rdata,
    input  load_ready, instruction, core_stall, fetch_fault, load_err,
           word_count, mem_we, mem_waddr, mem_wdata, mem_raddr
  );
endinterface

// File: rtl/imem_boot_ctrl.sv
// Instruction-memory boot controller: streams a program into memory while the
// core is stalled, then serves zero-latency word fetches from PCF.
module imem_boot_ctrl #(
  parameter int          DEPTH    = 32,
  parameter int          ADDR_W   = 5,
  parameter logic [31:0] NOP_WORD = 32'h0000_0013
) (
  input  logic         clk,
  input  logic         rst_n,
  imem_boot_if.master  bus
);

  localparam logic [1:0] S_LOAD = 2'd0;
  localparam logic [1:0] S_DONE = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;

  logic [1:0]        r_state;
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W:0]   r_word_count;
  logic              r_load_err;

  logic w_in_load;
  logic w_in_run;
  logic w_xfer;
  logic w_last_slot;
  logic w_pc_bad;
  logic w_fault;

  assign w_in_load   = (r_state == S_LOAD);
  assign w_in_run    = (r_state == S_RUN);
  // rst_n gates the write so an asserted reset never leaks a write to memory
  assign w_xfer      = rst_n & w_in_load & bus.load_valid;
  assign w_last_slot = (r_wr_ptr == ADDR_W'(DEPTH - 1));
  assign w_pc_bad    = (|bus.PCF[1:0]) | (bus.PCF >= 32'(4 * DEPTH));
  assign w_fault     = w_in_run & w_pc_bad;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_LOAD;
      r_wr_ptr     <= '0;
      r_word_count <= '0;
      r_load_err   <= 1'b0;
    end else begin
      case (r_state)
        S_LOAD: begin
          if (w_xfer) begin
            r_wr_ptr     <= r_wr_ptr + 1'b1;
            r_word_count <= r_word_count + 1'b1;
            if (bus.load_last) begin
              r_state <= S_DONE;
            end else if (w_last_slot) begin
              // memory full without an end marker: stop rather than wrap
              r_state    <= S_DONE;
              r_load_err <= 1'b1;
            end
          end
        end
        S_DONE: r_state <= S_RUN;
        S_RUN: begin
          if (bus.reload_req) begin
            r_state      <= S_LOAD;
            r_wr_ptr     <= '0;
            r_word_count <= '0;
            r_load_err   <= 1'b0;
          end
        end
        default: r_state <= S_LOAD;
      endcase
    end
  end

  assign bus.load_ready  = w_in_load;
  assign bus.core_stall  = ~w_in_run;
  assign bus.mem_we      = w_xfer;
  assign bus.mem_waddr   = r_wr_ptr;
  assign bus.mem_wdata   = bus.load_data;
  assign bus.mem_raddr   = w_in_run ? bus.PCF[ADDR_W+1:2] : '0;
  assign bus.fetch_fault = w_fault;
  assign bus.instruction = (w_in_run & ~w_fault) ? bus.mem_rdata : NOP_WORD;
  assign bus.word_count  = r_word_count;
  assign bus.load_err    = r_load_err;

endmodule

// File: tb/tb_imem_boot_ctrl.sv
// Bench for imem_boot_ctrl: async-read memory model plus a cycle-level reference
// of the load/run behaviour, driven by directed and randomized steps.
module tb_imem_boot_ctrl;
  localparam int          DEPTH  = 32;
  localparam int          ADDR_W = 5;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  typedef enum {M_LOAD, M_DONE, M_RUN} phase_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  imem_boot_if #(.ADDR_W(ADDR_W)) bus ();

  imem_boot_ctrl #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .NOP_WORD(NOP)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [31:0] tmem [DEPTH];
  initial begin
    for (int i = 0; i < DEPTH; i++) tmem[i] <= 32'hDEAD_0000 | 32'(i);
  end
  always @(posedge clk) if (bus.mem_we) tmem[bus.mem_waddr] <= bus.mem_wdata;
  assign bus.mem_rdata = tmem[bus.mem_raddr];

  // reference model
  phase_t      m_ph;
  int          m_ptr;
  int          m_cnt;
  logic        m_err;
  logic [31:0] ref_mem [DEPTH];

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic model_reset();
    m_ph = M_LOAD; m_ptr = 0; m_cnt = 0; m_err = 1'b0;
  endtask

  task automatic step(input logic v, input logic [31:0] d, input logic l,
                      input logic rl, input logic [31:0] pc);
    logic e_rdy, e_stall, e_we, e_fault;
    logic [31:0] e_instr, e_raddr;
    bus.load_valid = v; bus.load_data = d; bus.load_last = l;
    bus.reload_req = rl; bus.PCF = pc;
    #2;
    e_rdy = 0; e_stall = 1; e_we = 0; e_fault = 0; e_instr = NOP; e_raddr = 0;
    case (m_ph)
      M_LOAD: begin e_rdy = 1; e_we = v; end
      M_DONE: ;
      M_RUN: begin
        e_stall = 0;
        e_raddr = (pc / 4) % DEPTH;
        e_fault = (pc % 4 != 0) || (pc >= 4 * DEPTH);
        e_instr = e_fault ? NOP : ref_mem[e_raddr];
      end
    endcase
    chk("load_ready", 32'(bus.load_ready), 32'(e_rdy));
    chk("core_stall", 32'(bus.core_stall), 32'(e_stall));
    chk("mem_we", 32'(bus.mem_we), 32'(e_we));
    chk("fetch_fault", 32'(bus.fetch_fault), 32'(e_fault));
    chk("instruction", bus.instruction, e_instr);
    chk("mem_raddr", 32'(bus.mem_raddr), e_raddr);
    if (e_we) begin
      chk("mem_waddr", 32'(bus.mem_waddr), 32'(m_ptr));
      chk("mem_wdata", bus.mem_wdata, d);
    end
    case (m_ph)
      M_LOAD: if (v) begin
        ref_mem[m_ptr] = d;
        m_cnt++;
        if (l) m_ph = M_DONE;
        else if (m_ptr == DEPTH - 1) begin m_ph = M_DONE; m_err = 1'b1; end
        m_ptr++;
      end
      M_DONE: m_ph = M_RUN;
      M_RUN: if (rl) begin m_ph = M_LOAD; m_ptr = 0; m_cnt = 0; m_err = 1'b0; end
    endcase
    @(posedge clk); #1;
    chk("word_count", 32'(bus.word_count), 32'(m_cnt));
    chk("load_err", 32'(bus.load_err), 32'(m_err));
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, $urandom, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic mem_compare(input string tag);
    for (int i = 0; i < DEPTH; i++) chk(tag, tmem[i], ref_mem[i]);
  endtask

  function automatic logic [31:0] rand_pc();
    case ($urandom_range(0, 3))
      0, 1:    return 32'($urandom_range(0, DEPTH - 1) * 4);
      2:       return 32'($urandom_range(0, DEPTH - 1) * 4 + $urandom_range(1, 3));
      default: return $urandom | 32'h0000_0100;
    endcase
  endfunction

  task automatic reset_checks(input string tag);
    chk({tag, "_ready"}, 32'(bus.load_ready), 32'd1);
    chk({tag, "_stall"}, 32'(bus.core_stall), 32'd1);
    chk({tag, "_we"}, 32'(bus.mem_we), 32'd0);
    chk({tag, "_instr"}, bus.instruction, NOP);
    chk({tag, "_fault"}, 32'(bus.fetch_fault), 32'd0);
    chk({tag, "_wc"}, 32'(bus.word_count), 32'd0);
    chk({tag, "_err"}, 32'(bus.load_err), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = 32'hDEAD_0000 | 32'(i);
    rst_n = 1'b0;
    bus.load_valid = 1'b1; bus.load_data = 32'h1234_5678; bus.load_last = 1'b0;
    bus.reload_req = 1'b0; bus.PCF = 32'h14;
    model_reset();
    @(posedge clk); #1;
    reset_checks("reset");
    @(posedge clk); #3;
    rst_n = 1'b1;

    // 8-word program, end marker on word 7
    for (int i = 0; i < 8; i++) step(1'b1, 32'h00A0_0093 + 32'(i), i == 7, 1'b0, 32'h0);
    chk("done_stall", 32'(bus.core_stall), 32'd1);
    step(1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'h0);  // DONE: no write despite valid
    chk("run_wc", 32'(bus.word_count), 32'd8);

    // fetch
    step(1'b0, 32'h0, 1'b0, 1'b0, 32'h14);
    step(1'b0, 32'h0, 1'b0, 1'b0, 32'h16);
    step(1'b0, 32'h0, 1'b0, 1'b0, 32'h80);
    bus.PCF = 32'h14; #1;
    chk("pc14_raddr", 32'(bus.mem_raddr), 32'd5);
    chk("pc14_instr", bus.instruction, 32'h00A0_0098);
    for (int k = 0; k < 20; k++) step(1'b0, 32'h0, 1'b0, 1'b0, rand_pc());
    mem_compare("mem_t1");

    // full memory without end marker
    step(1'b0, 32'h0, 1'b0, 1'b1, 32'h0);
    for (int i = 0; i < DEPTH; i++) step(1'b1, $urandom, 1'b0, 1'b0, 32'h0);
    chk("full_err", 32'(bus.load_err), 32'd1);
    chk("full_wc", 32'(bus.word_count), 32'd32);
    step(1'b1, 32'hBAD0_BAD0, 1'b0, 1'b0, 32'h0);
    for (int k = 0; k < 10; k++) step(1'b0, 32'h0, 1'b0, 1'b0, rand_pc());
    mem_compare("mem_t3");

    // gapped loader stream, reload ignored outside RUN
    step(1'b0, 32'h0, 1'b0, 1'b1, 32'h0);
    for (int i = 0; i < 6; i++) begin
      step(1'b0, $urandom, 1'b1, 1'b1, 32'h0);
      step(1'b1, $urandom, i == 5, 1'b0, 32'h0);
    end
    step(1'b0, 32'h0, 1'b0, 1'b1, 32'h0);  // DONE
    chk("gap_wc_pre", 32'(bus.word_count), 32'd6);
    step(1'b0, 32'h0, 1'b0, 1'b0, 32'h8);

    // reload pulse then 3-word program
    step(1'b0, 32'h0, 1'b0, 1'b1, 32'h4);
    chk("rl_stall", 32'(bus.core_stall), 32'd1);
    chk("rl_ready", 32'(bus.load_ready), 32'd1);
    chk("rl_wc", 32'(bus.word_count), 32'd0);
    for (int i = 0; i < 3; i++) step(1'b1, $urandom, i == 2, 1'b0, 32'h0);
    idle(2);
    for (int k = 0; k < 12; k++) step(1'b0, 32'h0, 1'b0, 1'b0, rand_pc());
    mem_compare("mem_t5");

    // reset mid-load
    step(1'b0, 32'h0, 1'b0, 1'b1, 32'h0);
    for (int i = 0; i < 4; i++) step(1'b1, $urandom, 1'b0, 1'b0, 32'h0);
    bus.load_valid = 1'b1;
    rst_n = 1'b0; #1;
    model_reset();
    reset_checks("midrst");
    @(posedge clk); #3;
    reset_checks("midrst_hold");
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) step(1'b1, $urandom, i == 7, 1'b0, 32'h0);
    idle(2);
    for (int k = 0; k < 8; k++) step(1'b0, 32'h0, 1'b0, 1'b0, rand_pc());
    mem_compare("mem_t6");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish, expected finish");
    $fatal(1, "timeout");
  end
endmodule
